// File: rtl/uart_tx_pkg.sv
// Shared constants for the uart_tx block: register offsets, STATUS bit layout
// and transmitter FSM state encodings.
package uart_tx_pkg;

  localparam logic [2:0] REG_DATA   = 3'b000;
  localparam logic [2:0] REG_STATUS = 3'b100;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_EMPTY   = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  // The STATUS count field is 4 bits wide; deeper FIFOs report 15.
  function automatic logic [3:0] sat_count4(input int unsigned cnt);
    logic [3:0] res;
    if (cnt > 32'd15) res = 4'hF;
    else              res = cnt[3:0];
    return res;
  endfunction

endpackage

// File: rtl/tx_fifo.sv
// Byte FIFO feeding the UART transmitter; show-ahead read port, power-of-two depth.
module tx_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [W-1:0]             i_din,
  output logic [W-1:0]             o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_dout  = r_mem[r_rd_ptr];

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// Register-mapped 8N1 UART transmitter with a TX FIFO and sticky overflow flag.
//   state | meaning
//   IDLE  | line high, waiting for a queued byte
//   START | start bit (low) for CLKS_PER_BIT cycles
//   DATA  | data bits LSB first, one per CLKS_PER_BIT cycles
//   STOP  | stop bit (high); chains straight into START if more bytes wait
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [2:0]  i_reg_sel,
  input  logic        i_we,
  input  logic [31:0] i_di,
  output logic [31:0] o_do,
  output logic        o_txd
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] BIT_RELOAD = CW'(CLKS_PER_BIT - 1);

  tx_state_e     r_state;
  tx_state_e     w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [2:0]    r_bit_idx;
  logic [2:0]    w_bit_idx_nxt;
  logic [7:0]    r_shift;
  logic [7:0]    w_shift_nxt;
  logic          r_txd;
  logic          w_txd_nxt;
  logic          r_ovf;

  logic          w_pop;
  logic          w_push;
  logic          w_full;
  logic          w_empty;
  logic [AW:0]   w_count;
  logic [7:0]    w_fifo_dout;
  logic          w_wr_data;
  logic          w_wr_status;
  logic [31:0]   w_status;
  logic          w_unused_di;

  assign w_wr_data   = i_we && (i_reg_sel == REG_DATA);
  assign w_wr_status = i_we && (i_reg_sel == REG_STATUS);
  // Fullness is judged before any same-cycle pop, so a write to a full FIFO is lost.
  assign w_push      = w_wr_data && !w_full;
  assign w_unused_di = ^i_di[31:8];

  tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (8)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (i_di[7:0]),
    .o_dout  (w_fifo_dout),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_txd     <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shift   <= w_shift_nxt;
      r_txd     <= w_txd_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_pop         = 1'b0;
    w_txd_nxt     = 1'b1;

    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_fifo_dout;
          w_cnt_nxt   = BIT_RELOAD;
          w_state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (r_cnt == '0) begin
          w_cnt_nxt     = BIT_RELOAD;
          w_bit_idx_nxt = '0;
          w_state_nxt   = ST_DATA;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      ST_DATA: begin
        if (r_cnt == '0) begin
          w_cnt_nxt = BIT_RELOAD;
          if (r_bit_idx == 3'd7) begin
            w_bit_idx_nxt = '0;
            w_state_nxt   = ST_STOP;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      ST_STOP: begin
        if (r_cnt == '0) begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_shift_nxt = w_fifo_dout;
            w_cnt_nxt   = BIT_RELOAD;
            w_state_nxt = ST_START;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase

    // The line is registered from the next state so it never glitches.
    case (w_state_nxt)
      ST_START: w_txd_nxt = 1'b0;
      ST_DATA:  w_txd_nxt = w_shift_nxt[w_bit_idx_nxt];
      default:  w_txd_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_ovf <= 1'b0;
    end else if (w_wr_data && w_full) begin
      r_ovf <= 1'b1;
    end else if (w_wr_status && i_di[STAT_OVF]) begin
      r_ovf <= 1'b0;
    end
  end

  always_comb begin
    w_status                       = '0;
    w_status[STAT_BUSY]            = (r_state != ST_IDLE);
    w_status[STAT_FULL]            = w_full;
    w_status[STAT_EMPTY]           = w_empty;
    w_status[STAT_OVF]             = r_ovf;
    w_status[STAT_CNT_LSB +: 4]    = sat_count4(32'(w_count));
    o_do = '0;
    if (i_reg_sel == REG_STATUS) o_do = w_status;
  end

  assign o_txd = r_txd;

endmodule
